// File: rtl/mod_reduce_serial.sv
//------------------------------------------------------------------------------
// Module      : mod_reduce_serial
// Description : Bit-serial restoring divider, Q = X / M and R = X mod M, with a
//               start/done level handshake matching the upstream multiplier.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_reduce_serial #(
    parameter int X_WIDTH = 128,
    parameter int M_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [X_WIDTH-1:0] X,
    input  logic [M_WIDTH-1:0] M,
    output logic [X_WIDTH-1:0] Q,
    output logic [M_WIDTH-1:0] R,
    output logic               done,
    output logic               err,
    output logic               busy,
    output logic [7:0]         cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_XW = 8'(X_WIDTH);

    state_t             r_state;
    logic [X_WIDTH-1:0] r_xsh;
    logic [M_WIDTH-1:0] r_m;

    logic [M_WIDTH:0]   w_t;
    logic [M_WIDTH-1:0] w_diff;
    logic               w_ge;

    // Partial remainder keeps the carry-out of R so the compare never wraps.
    assign w_t    = {R, r_xsh[X_WIDTH-1]};
    assign w_ge   = (w_t >= {1'b0, r_m});
    assign w_diff = w_t[M_WIDTH-1:0] - r_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_xsh   <= '0;
            r_m     <= '0;
            Q       <= '0;
            R       <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_xsh   <= X;
                        r_m     <= M;
                        Q       <= '0;
                        R       <= '0;
                        cnt     <= '0;
                        done    <= 1'b0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_m == '0) begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        Q       <= '1;
                        R       <= '0;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else if (cnt < c_XW) begin
                        R     <= w_ge ? w_diff : w_t[M_WIDTH-1:0];
                        Q     <= {Q[X_WIDTH-2:0], w_ge};
                        r_xsh <= r_xsh << 1;
                        cnt   <= cnt + 8'd1;
                    end else begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Results and done persist into IDLE until the next accept.
                    if (!start) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mod_reduce_serial.sv
//------------------------------------------------------------------------------
// Module      : tb_mod_reduce_serial
// Description : Directed self-checking bench for mod_reduce_serial.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod_reduce_serial;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] X;
    logic [63:0]  M;
    logic [127:0] Q;
    logic [63:0]  R;
    logic         done;
    logic         err;
    logic         busy;
    logic [7:0]   cnt;

    int n_checks = 0;
    int n_errors = 0;

    mod_reduce_serial #(.X_WIDTH(128), .M_WIDTH(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .M     (M),
        .Q     (Q),
        .R     (R),
        .done  (done),
        .err   (err),
        .busy  (busy),
        .cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one accepting edge; returns with that edge (E0) just passed.
    task automatic accept(input logic [127:0] x, input logic [63:0] m, input bit hold);
        X     = x;
        M     = m;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    // Edges after E0 until done is seen; busy_steps counts busy cycles with cnt < 128.
    task automatic wait_done(output int edges, output int busy_steps);
        edges      = 0;
        busy_steps = 0;
        while (!done && edges < 300) begin
            if (busy && cnt < 8'd128) busy_steps++;
            tick();
            edges++;
        end
    endtask

    task automatic chk_result(input string tag, input logic [127:0] x, input logic [63:0] m,
                              input logic [127:0] eq, input logic [63:0] er);
        logic [191:0] recon;
        chk({tag, "_Q"}, Q, eq);
        chk({tag, "_R"}, {64'd0, R}, {64'd0, er});
        chk({tag, "_err"}, {127'd0, err}, 128'd0);
        recon = 192'(Q) * 192'(m) + 192'(R);
        chk({tag, "_identity"}, recon[127:0], x);
        chk({tag, "_R_lt_M"}, {127'd0, (R < m)}, 128'd1);
    endtask

    initial begin
        int edges;
        int bsteps;
        logic [127:0] qhold;
        logic [127:0] prod;
        logic [63:0]  pm;

        rst   = 1'b1;
        start = 1'b0;
        X     = '0;
        M     = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_Q", Q, 128'd0);
        chk("reset_R", {64'd0, R}, 128'd0);
        chk("reset_flags", {124'd0, done, err, busy, 1'b0}, 128'd0);
        chk("reset_cnt", {120'd0, cnt}, 128'd0);

        // 100 / 7 with a one-cycle start pulse.
        accept(128'd100, 64'd7, 1'b0);
        chk("basic_busy_after_accept", {127'd0, busy}, 128'd1);
        wait_done(edges, bsteps);
        chk("basic_latency", 128'(edges), 128'd129);
        chk("basic_busy_steps", 128'(bsteps), 128'd128);
        chk("basic_busy_low_at_done", {127'd0, busy}, 128'd0);
        chk_result("basic", 128'd100, 64'd7, 128'd14, 64'd2);
        tick();

        accept({128{1'b1}}, {64{1'b1}}, 1'b0);
        wait_done(edges, bsteps);
        chk_result("allones", {128{1'b1}}, {64{1'b1}}, 128'h1_0000_0000_0000_0001, 64'd0);
        tick();

        // Remainder reaches the top bit of R, forcing the 65-bit compare.
        accept({128{1'b1}}, 64'h8000_0000_0000_0000, 1'b0);
        wait_done(edges, bsteps);
        chk_result("carry", {128{1'b1}}, 64'h8000_0000_0000_0000,
                   128'h1_FFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        tick();

        accept(128'd5, 64'd9, 1'b0);
        wait_done(edges, bsteps);
        chk_result("x_lt_m", 128'd5, 64'd9, 128'd0, 64'd5);
        tick();

        accept(128'hDEAD_BEEF, 64'd1, 1'b0);
        wait_done(edges, bsteps);
        chk_result("m_one", 128'hDEAD_BEEF, 64'd1, 128'hDEAD_BEEF, 64'd0);
        tick();

        // Divide by zero: done and err by the second edge counting the accept edge.
        accept(128'h1234_5678, 64'd0, 1'b0);
        tick();
        chk("div0_done", {127'd0, done}, 128'd1);
        chk("div0_err", {127'd0, err}, 128'd1);
        chk("div0_Q", Q, {128{1'b1}});
        chk("div0_R", {64'd0, R}, 128'd0);
        chk("div0_busy", {127'd0, busy}, 128'd0);
        tick();

        // start held through completion: no retrigger.
        accept(128'd77, 64'd10, 1'b1);
        wait_done(edges, bsteps);
        chk("hold_latency", 128'(edges), 128'd129);
        qhold = Q;
        repeat (6) tick();
        chk("hold_done", {127'd0, done}, 128'd1);
        chk("hold_no_retrigger_busy", {127'd0, busy}, 128'd0);
        chk("hold_cnt", {120'd0, cnt}, 128'd128);
        chk("hold_Q", Q, qhold);
        chk("hold_Q_value", Q, 128'd7);
        start = 1'b0;
        tick();
        chk("idle_done_sticky", {127'd0, done}, 128'd1);
        accept(128'd50, 64'd6, 1'b0);
        chk("reaccept_done_drop", {127'd0, done}, 128'd0);
        wait_done(edges, bsteps);
        chk_result("reaccept", 128'd50, 64'd6, 128'd8, 64'd2);
        tick();

        // Reset mid-calculation at cnt == 40.
        accept(128'hFFFF_0000_1111, 64'd12345, 1'b0);
        edges = 0;
        while (cnt != 8'd40 && edges < 200) begin
            tick();
            edges++;
        end
        chk("midrst_reached_40", {120'd0, cnt}, 128'd40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_Q", Q, 128'd0);
        chk("midrst_R", {64'd0, R}, 128'd0);
        chk("midrst_flags", {125'd0, done, err, busy}, 128'd0);
        chk("midrst_cnt", {120'd0, cnt}, 128'd0);
        repeat (3) tick();
        chk("midrst_stays_idle", {119'd0, busy, cnt}, 128'd0);
        accept(128'd1000, 64'd33, 1'b0);
        wait_done(edges, bsteps);
        chk("postrst_latency", 128'(edges), 128'd129);
        chk_result("postrst", 128'd1000, 64'd33, 128'd30, 64'd10);
        tick();

        // Chained: a stand-in multiplier raises its done level after 64 cycles.
        prod = 128'(64'd123456789) * 128'(64'd987654321);
        pm   = 64'd1000000007;
        X    = prod;
        M    = pm;
        repeat (64) tick();
        start = 1'b1;
        tick();
        wait_done(edges, bsteps);
        chk("chain_latency", 128'(edges), 128'd129);
        chk_result("chain", prod, pm, prod / 128'(pm), 64'(prod % 128'(pm)));
        start = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mod_reduce_serial.md
Name: mod_reduce_serial

Overview:
- Bit-serial restoring divider placed directly downstream of the shift-add multiplier.
- Consumes the double-width product X and a modulus M, and produces quotient Q = X / M and remainder R = X mod M.
- Together with the multiplier it forms a modular-multiply datapath.
- Uses the same start/done level handshake as the multiplier, so the multiplier's done can drive this block's start.

Parameters:
- X_WIDTH, 128, dividend width; must be ≤ 255.
- M_WIDTH, 64, modulus width; must be < X_WIDTH.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE; level-sensitive.
- X  input  X_WIDTH  dividend; captured on the accepting edge.
- M  input  M_WIDTH  modulus; captured on the accepting edge.
- Q  output  X_WIDTH  quotient register.
- R  output  M_WIDTH  remainder register.
- done  output  1  result valid.
- err  output  1  divide-by-zero flag; valid while done=1.
- busy  output  1  high in CALC.
- cnt  output  8  iteration counter, for debug.

Behaviour:
- Reset: on any rising edge with rst=1, the next state is:
  - state=IDLE
  - Q=0, R=0, done=0, err=0, cnt=0
  - all internal registers 0
  - Reset overrides everything, including mid-CALC; the in-flight operation is lost.
- States:
  - IDLE=0, CALC=1, DONE=2.
  - The encoding 3 goes to IDLE on the next edge.
- IDLE:
  - On an edge with start=1 (edge E0), the block:
    - captures X into a shift register and M into a modulus register;
    - clears Q, R, cnt, done and err;
    - moves to CALC.
  - With start=0 the block holds all outputs.
- CALC, zero modulus:
  - On the first CALC edge with captured M==0, the block sets:
    - err=1, done=1
    - Q = all ones, R = 0
  - It then moves to DONE with no iterations.
- CALC, nonzero modulus: each edge with cnt < X_WIDTH performs one step.
  - Internal partial remainder T is M_WIDTH+1 bits wide: T = {R, msb of X shift register}.
  - If T ≥ {1'b0, M}: R = T − M and the shifted-in Q bit is 1.
  - Otherwise: R = T[M_WIDTH-1:0] and the shifted-in Q bit is 0.
  - Q shifts left with the new bit in the LSB.
  - The X shift register shifts left by 1.
  - cnt increments by 1.
  - The compare must use the full M_WIDTH+1 bits so that a carry-out of R is handled.
- CALC, completion:
  - The edge with cnt == X_WIDTH sets done=1 and moves to DONE.
  - Q and R are final after edge E_X_WIDTH.
  - done is visible after edge E_(X_WIDTH+1), so total latency is X_WIDTH+1 edges after acceptance.
- busy: 1 exactly while state==CALC.
- DONE:
  - Q, R, done and err hold.
  - The block returns to IDLE only on an edge with start=0.
  - A start held high does not retrigger.
  - done stays high in IDLE until the next start is accepted.
- start in CALC: ignored. X and M changes after E0 are ignored.
- Results:
  - Q is exact over the full X_WIDTH bits.
  - R < M always when err=0.
  - Q*M + R == X.

Test Plan:
- X=100, M=7, start pulsed one cycle -> Q=14, R=2, err=0, done rises exactly 129 edges after the accepting edge, busy high for 128 of those edges.
- X=2^128−1, M=2^64−1 -> Q=2^64+1, R=0. X=2^128−1, M=2^63 -> Q=2^65−1, R=2^63−1; this exercises the M_WIDTH+1 compare path.
- Edge cases:
  - X=5, M=9 -> Q=0, R=5.
  - X=0xDEADBEEF, M=1 -> Q=0xDEADBEEF, R=0.
  - M=0, any X -> err=1, done=1 two edges after acceptance, Q=all ones, R=0.
- start held high through completion -> exactly one operation, state stays DONE. Deassert start -> IDLE next edge, done still 1. Reassert with X=50, M=6 -> done drops on the accept edge, then Q=8, R=2.
- rst asserted for one edge at cnt=40 -> next cycle all outputs 0 and state IDLE. A new start with X=1000, M=33 -> Q=30, R=10 with normal latency.
- Chained with the multiplier, A=123456789, B=987654321 with multiplier done driving start, M=1000000007 -> R equals (A*B) mod M from the reference model, err=0.
